// File: rtl/sync_lock_fsm_if.sv
// Bus between the peak-statistics counter / status block and the
// frame-sync lock decision stage. The master drives window statistics and
// thresholds; the slave (sync_lock_fsm) returns lock status and events.
interface sync_lock_fsm_if #(
    parameter int pST_W = 8
);
    logic             iena;
    logic             ival;
    logic [pST_W-1:0] istat;
    logic [pST_W-1:0] ithr_lock;
    logic [pST_W-1:0] ithr_loss;
    logic             olock;
    logic [1:0]       ostate;
    logic             oacq_pulse;
    logic             oloss_pulse;
    logic [15:0]      oloss_cnt;

    modport master (
        output iena, ival, istat, ithr_lock, ithr_loss,
        input  olock, ostate, oacq_pulse, oloss_pulse, oloss_cnt
    );

    modport slave (
        input  iena, ival, istat, ithr_lock, ithr_loss,
        output olock, ostate, oacq_pulse, oloss_pulse, oloss_cnt
    );
endinterface

// File: rtl/sync_lock_fsm.sv
// Frame-sync lock decision stage. Each valid window count is classified as
// good (>= ithr_lock) or bad (< ithr_loss); lock is declared after pACQ_N
// consecutive good windows and dropped after pLOSS_N consecutive bad ones,
// with a hysteresis band in HOLD that neither advances nor clears the miss run.
// Optional macro SYNC_LOCK_LOSS_CNT_EN enables the saturating lock-loss counter.
module sync_lock_fsm #(
    parameter int pST_W   = 8,
    parameter int pACQ_N  = 3,
    parameter int pLOSS_N = 4
) (
    input  logic          iclk,
    input  logic          ireset,
    sync_lock_fsm_if.slave bus
);
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [3:0] ACQ_N  = 4'(pACQ_N);
    localparam logic [3:0] LOSS_N = 4'(pLOSS_N);

    logic [1:0] state, state_nx;
    logic [3:0] run, run_nx;
    logic [3:0] miss, miss_nx;
    logic       acq_q, acq_nx;
    logic       loss_q, loss_nx;
    logic       good, bad;

    assign good = (bus.istat >= bus.ithr_lock);
    assign bad  = (bus.istat <  bus.ithr_loss);

    // Next-state decision for one evaluation; non-ival cycles hold state and drop pulses.
    always_comb begin
        state_nx = state;
        run_nx   = run;
        miss_nx  = miss;
        acq_nx   = 1'b0;
        loss_nx  = 1'b0;
        if (bus.ival) begin
            case (state)
                ST_SEARCH: begin
                    if (good) begin
                        if (ACQ_N == 4'd1) begin
                            state_nx = ST_LOCKED;
                            acq_nx   = 1'b1;
                            run_nx   = 4'd0;
                        end else begin
                            state_nx = ST_VERIFY;
                            run_nx   = 4'd1;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (good) begin
                        if (run + 4'd1 == ACQ_N) begin
                            state_nx = ST_LOCKED;
                            acq_nx   = 1'b1;
                            run_nx   = 4'd0;
                        end else begin
                            run_nx = run + 4'd1;
                        end
                    end else begin
                        state_nx = ST_SEARCH;
                        run_nx   = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    // bad is tested first so a misconfigured overlap drops lock
                    if (bad) begin
                        if (LOSS_N == 4'd1) begin
                            state_nx = ST_SEARCH;
                            loss_nx  = 1'b1;
                            miss_nx  = 4'd0;
                        end else begin
                            state_nx = ST_HOLD;
                            miss_nx  = 4'd1;
                        end
                    end else begin
                        miss_nx = 4'd0;
                    end
                end
                ST_HOLD: begin
                    if (bad) begin
                        if (miss + 4'd1 == LOSS_N) begin
                            state_nx = ST_SEARCH;
                            loss_nx  = 1'b1;
                            miss_nx  = 4'd0;
                        end else begin
                            miss_nx = miss + 4'd1;
                        end
                    end else if (good) begin
                        state_nx = ST_LOCKED;
                        miss_nx  = 4'd0;
                    end
                end
                default: begin
                    state_nx = ST_SEARCH;
                    run_nx   = 4'd0;
                    miss_nx  = 4'd0;
                end
            endcase
        end
    end

    // State, counters and pulse registers; iena low freezes everything.
    always_ff @(posedge iclk) begin
        if (!ireset) begin
            state  <= ST_SEARCH;
            run    <= 4'd0;
            miss   <= 4'd0;
            acq_q  <= 1'b0;
            loss_q <= 1'b0;
        end else if (bus.iena) begin
            state  <= state_nx;
            run    <= run_nx;
            miss   <= miss_nx;
            acq_q  <= acq_nx;
            loss_q <= loss_nx;
        end
    end

`ifdef SYNC_LOCK_LOSS_CNT_EN
    logic [15:0] loss_cnt;

    // Saturating lock-loss event counter, updated together with the loss pulse.
    always_ff @(posedge iclk) begin
        if (!ireset) begin
            loss_cnt <= 16'd0;
        end else if (bus.iena && loss_nx && (loss_cnt != 16'hFFFF)) begin
            loss_cnt <= loss_cnt + 16'd1;
        end
    end

    assign bus.oloss_cnt = loss_cnt;
`else
    assign bus.oloss_cnt = 16'd0;
`endif

    assign bus.ostate      = state;
    assign bus.olock       = state[1];
    assign bus.oacq_pulse  = acq_q;
    assign bus.oloss_pulse = loss_q;
endmodule

// File: tb/tb_sync_lock_fsm.sv
// Directed bench for sync_lock_fsm: acquire, failed verify, loss, hysteresis,
// enable gating, mid-state reset and threshold boundaries.
module tb_sync_lock_fsm;
    logic iclk = 1'b0;
    logic ireset;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   exp_losses = 0;

    sync_lock_fsm_if #(.pST_W(8)) bus ();

    sync_lock_fsm #(.pST_W(8), .pACQ_N(3), .pLOSS_N(4)) dut (
        .iclk   (iclk),
        .ireset (ireset),
        .bus    (bus)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compare every output against the expected state and pulse values.
    task automatic chk_out(input string tag, input logic [1:0] st, input logic acq, input logic loss);
        logic [15:0] exp_cnt;
`ifdef SYNC_LOCK_LOSS_CNT_EN
        exp_cnt = 16'(exp_losses);
`else
        exp_cnt = 16'd0;
`endif
        chk({tag, ".ostate"}, 16'(bus.ostate), 16'(st));
        chk({tag, ".olock"}, 16'(bus.olock), 16'(st[1]));
        chk({tag, ".acq"}, 16'(bus.oacq_pulse), 16'(acq));
        chk({tag, ".loss"}, 16'(bus.oloss_pulse), 16'(loss));
        chk({tag, ".cnt"}, bus.oloss_cnt, exp_cnt);
    endtask

    // One ival strobe; returns on the negedge after the evaluating posedge.
    task automatic strobe(input logic [7:0] v);
        @(negedge iclk);
        bus.istat = v;
        bus.ival  = 1'b1;
        @(negedge iclk);
        bus.ival  = 1'b0;
        bus.istat = 8'hAA;
    endtask

    task automatic idle();
        @(negedge iclk);
    endtask

    initial begin
        ireset        = 1'b0;
        bus.iena      = 1'b1;
        bus.ival      = 1'b0;
        bus.istat     = 8'd0;
        bus.ithr_lock = 8'd10;
        bus.ithr_loss = 8'd4;
        repeat (3) @(negedge iclk);
        chk_out("reset", 2'd0, 1'b0, 1'b0);
        ireset = 1'b1;
        idle();
        chk_out("post_reset", 2'd0, 1'b0, 1'b0);

        // Acquire
        strobe(8'd12); chk_out("acq1", 2'd1, 1'b0, 1'b0);
        strobe(8'd15); chk_out("acq2", 2'd1, 1'b0, 1'b0);
        strobe(8'd10); chk_out("acq3", 2'd2, 1'b1, 1'b0);
        idle();        chk_out("acq_idle", 2'd2, 1'b0, 1'b0);

        // Loss
        strobe(8'd3); chk_out("loss1", 2'd3, 1'b0, 1'b0);
        strobe(8'd2); chk_out("loss2", 2'd3, 1'b0, 1'b0);
        strobe(8'd0); chk_out("loss3", 2'd3, 1'b0, 1'b0);
        exp_losses = 1;
        strobe(8'd1); chk_out("loss4", 2'd0, 1'b0, 1'b1);
        idle();       chk_out("loss_idle", 2'd0, 1'b0, 1'b0);

        // Failed verify
        strobe(8'd12); chk_out("fv1", 2'd1, 1'b0, 1'b0);
        strobe(8'd9);  chk_out("fv2", 2'd0, 1'b0, 1'b0);

        // Re-acquire, then hysteresis back to LOCKED without acq pulse
        strobe(8'd12); strobe(8'd12); strobe(8'd12);
        chk_out("reacq", 2'd2, 1'b1, 1'b0);
        strobe(8'd3);  chk_out("hys1", 2'd3, 1'b0, 1'b0);
        strobe(8'd6);  chk_out("hys2", 2'd3, 1'b0, 1'b0);
        strobe(8'd6);  chk_out("hys3", 2'd3, 1'b0, 1'b0);
        strobe(8'd11); chk_out("hys4", 2'd2, 1'b0, 1'b0);
        strobe(8'd3);  chk_out("hys5", 2'd3, 1'b0, 1'b0);
        strobe(8'd3);  chk_out("hys6", 2'd3, 1'b0, 1'b0);
        strobe(8'd3);  chk_out("hys7", 2'd3, 1'b0, 1'b0);
        exp_losses = 2;
        strobe(8'd3);  chk_out("hys8", 2'd0, 1'b0, 1'b1);

        // Band windows hold miss: 1 bad, 2 band, then 3 more bad drops lock
        strobe(8'd12); strobe(8'd12); strobe(8'd12);
        chk_out("reacq2", 2'd2, 1'b1, 1'b0);
        strobe(8'd3);  strobe(8'd6); strobe(8'd6);
        chk_out("band1", 2'd3, 1'b0, 1'b0);
        strobe(8'd3);  strobe(8'd3);
        chk_out("band2", 2'd3, 1'b0, 1'b0);
        exp_losses = 3;
        strobe(8'd3);  chk_out("band3", 2'd0, 1'b0, 1'b1);

        // Enable gating
        strobe(8'd12); strobe(8'd12); strobe(8'd12);
        chk_out("reacq3", 2'd2, 1'b1, 1'b0);
        idle();
        bus.iena = 1'b0;
        strobe(8'd0);  chk_out("ena_off1", 2'd2, 1'b0, 1'b0);
        bus.iena = 1'b1;
        idle();        chk_out("ena_on", 2'd2, 1'b0, 1'b0);
        strobe(8'd3);  chk_out("hold_in", 2'd3, 1'b0, 1'b0);
        bus.iena = 1'b0;
        strobe(8'd0); strobe(8'd0); strobe(8'd0);
        chk_out("ena_off2", 2'd3, 1'b0, 1'b0);
        bus.iena = 1'b1;

        // One-cycle reset in HOLD
        @(negedge iclk);
        ireset = 1'b0;
        @(negedge iclk);
        ireset = 1'b1;
        exp_losses = 0;
        chk_out("rst_hold", 2'd0, 1'b0, 1'b0);

        // History discarded: one bad only keeps SEARCH
        strobe(8'd3);  chk_out("srch_bad", 2'd0, 1'b0, 1'b0);

        // Threshold boundaries: istat==ithr_lock is good, istat==ithr_loss is not bad
        strobe(8'd10); strobe(8'd10); strobe(8'd10);
        chk_out("bnd_lock", 2'd2, 1'b1, 1'b0);
        strobe(8'd4);  chk_out("bnd_loss", 2'd2, 1'b0, 1'b0);
        bus.ithr_loss = 8'd0;
        strobe(8'd0);  chk_out("thr0_a", 2'd2, 1'b0, 1'b0);
        strobe(8'd0);  chk_out("thr0_b", 2'd2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
